// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller.
package dmem_pkg;

    // Access sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    // Address regions seen by the decoder.
    typedef enum logic [1:0] {
        RGN_RAM      = 2'd0,
        RGN_MMIO     = 2'd1,
        RGN_UNMAPPED = 2'd2
    } region_e;

    // MMIO register offsets (addr[1:0] inside the MMIO page).
    localparam logic [1:0] MMIO_GPIO_OUT = 2'd0;
    localparam logic [1:0] MMIO_GPIO_IN  = 2'd1;
    localparam logic [1:0] MMIO_CYCLES   = 2'd2;
    localparam logic [1:0] MMIO_STATUS   = 2'd3;

    // Sticky error flag position inside STATUS.
    localparam int STATUS_ERR_BIT = 0;

    // RAM below DEPTH, MMIO when the address MSB is set, otherwise unmapped.
    function automatic region_e decode_region(input logic [31:0] addr,
                                              input int          width,
                                              input int          depth);
        if (addr < $unsigned(depth)) begin
            return RGN_RAM;
        end else if (addr[width-1]) begin
            return RGN_MMIO;
        end
        return RGN_UNMAPPED;
    endfunction

endpackage

// File: rtl/ram_sp.sv
// Single-port synchronous RAM with registered read data.
module ram_sp #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 128
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wd,
    output logic [WIDTH-1:0]         rd
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port and registered read port (read returns pre-write contents).
    // NOTE: the storage array deliberately has no reset; clearing it would
    // need one write per word and the contents are undefined at power-up.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wd;
        end
        rd <= mem_q[addr];
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: wait-stated RAM access, MMIO page, error detection.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int WIDTH = 17,
    parameter int DEPTH = 128,
    parameter int WAIT  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             we,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             stall,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] gpio_out,
    input  logic [WIDTH-1:0] gpio_in
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             capture, access;
    logic             we_q;
    logic [WIDTH-1:0] addr_q, wdata_q, rdata_q;
    logic             err_q, status_q;
    logic [WIDTH-1:0] gpio_out_q, sync1_q, sync2_q, cycles_q;
    logic [WIDTH-1:0] load_val, ram_rd;
    logic [AW-1:0]    ram_addr;
    logic             ram_we, mmio_hit;
    region_e          region;

    assign region   = decode_region(32'(addr_q), WIDTH, DEPTH);
    assign mmio_hit = access && we_q && (region == RGN_MMIO);
    // While idle the RAM sees the live core address so its registered read
    // is already valid by the commit edge, even with no wait states.
    assign ram_addr = (state_q == IDLE) ? addr[AW-1:0] : addr_q[AW-1:0];
    assign ram_we   = access && we_q && (region == RGN_RAM);

    ram_sp #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .wd   (wdata_q),
        .rd   (ram_rd)
    );

    // State and wait counter register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: capture, count down wait states, access, respond.
    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        access  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = BUSY;
                    cnt_d   = WAIT_CNT;
                    capture = 1'b1;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    access  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Load data source for the captured address.
    always_comb begin
        load_val = '0;
        if (region == RGN_RAM) begin
            load_val = ram_rd;
        end else if (region == RGN_MMIO) begin
            unique case (addr_q[1:0])
                MMIO_GPIO_OUT: load_val = gpio_out_q;
                MMIO_GPIO_IN:  load_val = sync2_q;
                MMIO_CYCLES:   load_val = cycles_q;
                default:       load_val[STATUS_ERR_BIT] = status_q;
            endcase
        end
    end

    // Request capture, access commit, MMIO writes and sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            status_q   <= 1'b0;
            gpio_out_q <= '0;
        end else begin
            if (capture) begin
                we_q    <= we;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (access) begin
                err_q <= (region == RGN_UNMAPPED);
                if (!we_q) begin
                    rdata_q <= load_val;
                end
            end
            if (mmio_hit && addr_q[1:0] == MMIO_GPIO_OUT) begin
                gpio_out_q <= wdata_q;
            end
            // A new error takes priority over a simultaneous clear.
            if (access && region == RGN_UNMAPPED) begin
                status_q <= 1'b1;
            end else if (mmio_hit && addr_q[1:0] == MMIO_STATUS && wdata_q[STATUS_ERR_BIT]) begin
                status_q <= 1'b0;
            end
        end
    end

    // Free-running cycle counter and two-flop GPIO input synchroniser.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycles_q <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
        end else begin
            cycles_q <= cycles_q + 1'b1;
            sync1_q  <= gpio_in;
            sync2_q  <= sync1_q;
        end
    end

    assign rdata    = rdata_q;
    assign gpio_out = gpio_out_q;
    assign done     = (state_q == RESP);
    assign err      = (state_q == RESP) && err_q;
    assign stall    = req && (state_q != RESP) && reset;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: five instances with different WAIT values.
module tb_dmem_ctrl;

    localparam int NI = 5;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [NI-1:0]   req;
    logic            we;
    logic [16:0]     addr, wdata, gpio_in;
    logic [16:0]     rdata [NI];
    logic [16:0]     gpio_out [NI];
    logic [NI-1:0]   stall, done, err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Instance k uses WAIT = 2, 0, 1, 5, 15 for k = 0..4.
    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int WV = (g == 0) ? 2 : (g == 1) ? 0 : (g == 2) ? 1 : (g == 3) ? 5 : 15;
        dmem_ctrl #(.WIDTH(17), .DEPTH(128), .WAIT(WV)) u_dut (
            .clk      (clk),
            .reset    (reset),
            .req      (req[g]),
            .we       (we),
            .addr     (addr),
            .wdata    (wdata),
            .rdata    (rdata[g]),
            .stall    (stall[g]),
            .done     (done[g]),
            .err      (err[g]),
            .gpio_out (gpio_out[g]),
            .gpio_in  (gpio_in)
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // One access on instance k; call at a falling edge. Returns at the done
    // cycle (falling edge + 1) with req released.
    task automatic access(input int k, input logic w, input logic [16:0] a, input logic [16:0] d,
                          output logic [16:0] rd, output logic e, output int nstall, output int ncyc);
        req[k] = 1'b1;
        we     = w;
        addr   = a;
        wdata  = d;
        nstall = 0;
        ncyc   = 0;
        #1;
        while (!done[k] && ncyc < 40) begin
            if (stall[k]) nstall++;
            ncyc++;
            @(negedge clk);
            #1;
        end
        check("done_seen", 32'(done[k]), 32'd1);
        rd     = rdata[k];
        e      = err[k];
        req[k] = 1'b0;
    endtask

    typedef struct {
        logic        w;
        logic [16:0] a;
        logic [16:0] d;
        logic        chk_rd;
        logic [16:0] exp_rd;
        logic        exp_err;
        logic [16:0] exp_gpio;
    } vec_t;

    vec_t        vecs [16];
    logic [16:0] rd, c1, c2;
    logic        e;
    int          ns, nc;

    initial begin
        // st/ld on the WAIT=2 instance; rdata must also hold across stores.
        vecs[0]  = '{1'b1, 17'h00005, 17'h1ABCD, 1'b0, 17'h00000, 1'b0, 17'h00000};
        vecs[1]  = '{1'b0, 17'h00005, 17'h00000, 1'b1, 17'h1ABCD, 1'b0, 17'h00000};
        vecs[2]  = '{1'b1, 17'h0007F, 17'h0F0F0, 1'b1, 17'h1ABCD, 1'b0, 17'h00000};
        vecs[3]  = '{1'b0, 17'h0007F, 17'h00000, 1'b1, 17'h0F0F0, 1'b0, 17'h00000};
        vecs[4]  = '{1'b0, 17'h00080, 17'h00000, 1'b1, 17'h00000, 1'b1, 17'h00000};
        vecs[5]  = '{1'b0, 17'h10003, 17'h00000, 1'b1, 17'h00001, 1'b0, 17'h00000};
        vecs[6]  = '{1'b1, 17'h10003, 17'h00000, 1'b1, 17'h00001, 1'b0, 17'h00000};
        vecs[7]  = '{1'b0, 17'h10003, 17'h00000, 1'b1, 17'h00001, 1'b0, 17'h00000};
        vecs[8]  = '{1'b1, 17'h10003, 17'h00001, 1'b0, 17'h00000, 1'b0, 17'h00000};
        vecs[9]  = '{1'b0, 17'h10003, 17'h00000, 1'b1, 17'h00000, 1'b0, 17'h00000};
        vecs[10] = '{1'b1, 17'h10000, 17'h00055, 1'b0, 17'h00000, 1'b0, 17'h00055};
        vecs[11] = '{1'b0, 17'h10000, 17'h00000, 1'b1, 17'h00055, 1'b0, 17'h00055};
        vecs[12] = '{1'b1, 17'h00200, 17'h12345, 1'b0, 17'h00000, 1'b1, 17'h00055};
        vecs[13] = '{1'b0, 17'h00200, 17'h00000, 1'b1, 17'h00000, 1'b1, 17'h00055};
        vecs[14] = '{1'b1, 17'h10001, 17'h1FFFF, 1'b0, 17'h00000, 1'b0, 17'h00055};
        vecs[15] = '{1'b0, 17'h10001, 17'h00000, 1'b1, 17'h00000, 1'b0, 17'h00055};

        req = '0; we = 1'b0; addr = '0; wdata = '0; gpio_in = '0;

        // Reset state, with a pending request that must not raise stall.
        repeat (2) @(negedge clk);
        req[0] = 1'b1;
        #1;
        check("rst_stall", 32'(stall[0]), 32'd0);
        check("rst_done",  32'(done[0]),  32'd0);
        check("rst_err",   32'(err[0]),   32'd0);
        check("rst_rdata", 32'(rdata[0]), 32'd0);
        check("rst_gpio",  32'(gpio_out[0]), 32'd0);
        req[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // Table-driven accesses on WAIT=2.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            access(0, vecs[i].w, vecs[i].a, vecs[i].d, rd, e, ns, nc);
            check($sformatf("v%0d_stall", i), 32'(ns), 32'd4);
            check($sformatf("v%0d_lat", i),   32'(nc), 32'd4);
            check($sformatf("v%0d_err", i),   32'(e),  32'(vecs[i].exp_err));
            check($sformatf("v%0d_gpio", i),  32'(gpio_out[0]), 32'(vecs[i].exp_gpio));
            if (vecs[i].chk_rd) check($sformatf("v%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rd));
            @(negedge clk);
            #1;
            check($sformatf("v%0d_done_pulse", i), 32'({done[0], err[0]}), 32'd0);
        end

        // RAM still intact after the dropped unmapped store.
        @(negedge clk);
        access(0, 1'b0, 17'h00005, 17'h0, rd, e, ns, nc);
        check("ram_after_unmapped", 32'(rd), 32'h1ABCD);

        // GPIO input through the synchroniser.
        @(negedge clk);
        gpio_in = 17'h00003;
        repeat (2) @(negedge clk);
        access(0, 1'b0, 17'h10001, 17'h0, rd, e, ns, nc);
        check("gpio_in_3", 32'(rd), 32'h3);
        // WAIT=0: the value read one edge after a change is still the old one.
        @(negedge clk);
        gpio_in = 17'h00005;
        access(1, 1'b0, 17'h10001, 17'h0, rd, e, ns, nc);
        check("gpio_in_sync_old", 32'(rd), 32'h3);
        @(negedge clk);
        access(1, 1'b0, 17'h10001, 17'h0, rd, e, ns, nc);
        check("gpio_in_sync_new", 32'(rd), 32'h5);

        // Back-to-back CYCLES loads with WAIT=0.
        @(negedge clk);
        access(1, 1'b0, 17'h10002, 17'h0, c1, e, ns, nc);
        @(negedge clk);
        access(1, 1'b0, 17'h10002, 17'h0, c2, e, ns, nc);
        check("cycles_delta", 32'(17'(c2 - c1)), 32'd3);

        // Counter wrap: preload all-ones; the BUSY cycle then sees 0.
        @(negedge clk);
        force g_dut[1].u_dut.cycles_q = 17'h1FFFF;
        #1;
        release g_dut[1].u_dut.cycles_q;
        access(1, 1'b0, 17'h10002, 17'h0, rd, e, ns, nc);
        check("cycles_wrap", 32'(rd), 32'd0);

        // Reset during BUSY of a store on WAIT=5.
        @(negedge clk);
        access(3, 1'b1, 17'h00007, 17'h00111, rd, e, ns, nc);
        @(negedge clk);
        access(3, 1'b0, 17'h00007, 17'h0, rd, e, ns, nc);
        check("pre_rst_ld7", 32'(rd), 32'h00111);
        @(negedge clk);
        req[3] = 1'b1; we = 1'b1; addr = 17'h00007; wdata = 17'h1EEEE;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_stall",  32'(stall[3]),    32'd0);
        check("mid_rst_rdata3", 32'(rdata[3]),    32'd0);
        check("mid_rst_gpio0",  32'(gpio_out[0]), 32'd0);
        check("mid_rst_rdata0", 32'(rdata[0]),    32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("mid_rst_no_done", 32'({done[3], err[3]}), 32'd0);
        end
        req[3] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("post_rst_no_done", 32'(done[3]), 32'd0);
        @(negedge clk);
        access(3, 1'b0, 17'h00007, 17'h0, rd, e, ns, nc);
        check("ld7_old_contents", 32'(rd), 32'h00111);
        check("ld7_wait5_stall", 32'(ns), 32'd7);

        // Stall length sweep for WAIT = 0, 1, 15.
        for (int k = 1; k < NI; k++) begin
            int wv;
            wv = (k == 1) ? 0 : (k == 2) ? 1 : (k == 3) ? 5 : 15;
            if (k == 3) continue;
            @(negedge clk);
            access(k, 1'b1, 17'h00010, 17'h00AAA, rd, e, ns, nc);
            check($sformatf("sweep_w%0d_stall", wv), 32'(ns), 32'(wv + 2));
            check($sformatf("sweep_w%0d_lat", wv),   32'(nc), 32'(wv + 2));
            @(negedge clk);
            access(k, 1'b0, 17'h00010, 17'h0, rd, e, ns, nc);
            check($sformatf("sweep_w%0d_rdata", wv), 32'(rd), 32'h00AAA);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised data-memory controller sitting between the 17-bit MIPS core's load/store port and on-chip data storage. It is the next-generation replacement for the fixed single-cycle data memory. It adds configurable wait states with a stall handshake to the core, a small memory-mapped I/O page (GPIO, cycle counter, status), and out-of-range access detection. Instruction fetch is unaffected.

## Interface
- WIDTH, 17, data and address width in bits.
- DEPTH, 128, RAM words; AW = clog2(DEPTH).
- WAIT, 2, extra access cycles, legal range 0..15.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
- req  in  1  core requests a load/store; held with we/addr/wdata stable while stall=1.
- we  in  1  1 = store, 0 = load.
- addr  in  WIDTH  word address.
- wdata  in  WIDTH  store data.
- rdata  out  WIDTH  load data; valid when done=1; holds until the next load completes.
- stall  out  1  freeze the core; combinational.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse with done when the access hit an unmapped address.
- gpio_out  out  WIDTH  GPIO output register.
- gpio_in  in  WIDTH  asynchronous GPIO inputs.

## Operation
- Address decode on the captured address:
  - RAM when addr < DEPTH; index = addr[AW-1:0].
  - MMIO when addr[WIDTH-1] = 1; register select = addr[1:0].
  - Anything else is unmapped.
- MMIO registers:
  - 0 GPIO_OUT: read/write.
  - 1 GPIO_IN: read-only; 2-flop synchroniser output.
  - 2 CYCLES: read-only; free-running WIDTH-bit counter that wraps to 0.
  - 3 STATUS: bit0 = sticky error, write 1 to clear; other bits read 0.
  - Writes to read-only registers are ignored.
- Unmapped access: store is dropped, load returns 0, err pulses, STATUS.bit0 is set.
- FSM states: IDLE, BUSY, RESP.
  - IDLE with req=1: capture we/addr/wdata, cnt←WAIT, go to BUSY.
  - BUSY with cnt≠0: cnt←cnt−1.
  - BUSY with cnt=0: perform the access (store commits, load result is registered into rdata), go to RESP.
  - RESP: done=1, then go to IDLE unconditionally.
- stall = req AND (state ≠ RESP). It is forced to 0 while reset is asserted.
- STATUS clear and a new error in the same cycle: set wins.
- A CYCLES load returns the counter value in the BUSY cycle where cnt=0.

## Timing
- Request first seen at edge N: access performed at edge N+1+WAIT, done high during cycle N+WAIT+2. The core stalls for WAIT+2 cycles.
- Back-to-back requests: one access every WAIT+3 cycles. The core presents the next request after the RESP edge.
- Reset values:
  - state IDLE; cnt 0.
  - rdata, gpio_out, CYCLES, STATUS, synchroniser flops: all 0.
  - done, err, stall: 0.
  - RAM contents are not reset.
- Reset mid-BUSY aborts: a store whose commit edge has not occurred is not written. No done pulse.
- With WAIT=0 the BUSY state lasts exactly one cycle.
- gpio_in reaches the GPIO_IN register 2 edges after it changes.

## Structure
- Package dmem_pkg holds:
  - the state enum (IDLE/BUSY/RESP);
  - MMIO register offsets and the STATUS bit index;
  - a region decode function returning RAM/MMIO/UNMAPPED.
- One sub-module, ram_sp: single-port synchronous RAM, WIDTH×DEPTH, with we, addr, wd and registered rd.
- The FSM, decode, MMIO registers, counter and synchroniser live in dmem_ctrl.

## Test plan
- WAIT=2: store 0x1ABCD to addr 5, then load addr 5 → stall high for 4 cycles each, done on the 4th cycle after req, rdata=0x1ABCD.
- Store to 0x10000 (GPIO_OUT) with wdata 0x00055 → gpio_out=0x00055 on the commit edge. Then drive gpio_in=0x00003; a load from 0x10001 issued 2+ cycles later → rdata=0x00003.
- Load 0x00200 (unmapped) → rdata=0, err pulses with done, STATUS.bit0=1. Store 0x1 to 0x10003 → bit0=0. Clear and a new error in the same cycle → bit0 stays 1.
- CYCLES: two loads from 0x10002 issued back-to-back with WAIT=0 → values differ by 3. Preloading the counter to 0x1FFFF → wraps to 0.
- Assert reset during BUSY of a store to addr 7 (WAIT=5) → no done. A later load of addr 7 returns the old contents; all outputs are 0 during reset.
- Sweep WAIT = 0, 1 and 15 → stall length equals WAIT+2 in every case.
